ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
- PS/2 keyboard receive front end; feeds scancodes to the CPU core's keyboard port.
- Synchronises and deglitches raw ps2CLK/ps2DATA and deframes 11-bit device-to-host frames.
- Buffers valid bytes in a small first-word-fall-through FIFO.
- Raises ps2Inhibit while the FIFO is full. The top level converts the rising edge of ps2Inhibit into its clock-low inhibit pulse.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries of 8 bits.
- FILTER_LEN, 4, clk cycles a synchronised PS/2 line must hold a new level before the filtered value changes.
- TIMEOUT, 100000, clk cycles allowed between filtered falling edges inside a frame (2 ms at 50 MHz).
- TO_W, 17, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_in  in  1  asynchronous reset, active-low
- ps2CLK  in  1  raw PS/2 clock (asynchronous)
- ps2DATA  in  1  raw PS/2 data (asynchronous)
- rdEn  in  1  pop head entry; honoured only when rdValid=1
- rdData  out  8  head entry; meaningful only when rdValid=1
- rdValid  out  1  FIFO not empty
- count  out  FIFO_AW+1  entries currently held
- ps2Inhibit  out  1  FIFO full
- frameErr  out  1  one-cycle pulse per rejected frame
- overflow  out  1  one-cycle pulse per good frame dropped because the FIFO was full
- errCount  out  8  saturating error count (see Optional Feature)

Behaviour:
- Reset (rst_in low, asynchronous):
  - rdData=0, rdValid=0, count=0, ps2Inhibit=0, frameErr=0, overflow=0, errCount=0.
  - FSM=IDLE; FIFO pointers 0.
  - Synchronisers and filters preset to 1 (idle bus).
- Input conditioning:
  - Each line passes a 2-FF synchroniser, then a filter. The filter output flips only after FILTER_LEN consecutive cycles at the opposite level.
  - fall = filtered clock 1 -> 0, one cycle wide. Data is sampled from filtered data in the fall cycle.
- FSM states:
  - IDLE: on fall, data=0 -> DATA with bitCnt=0; data=1 -> frameErr, stay IDLE.
  - DATA: on fall, shift data in LSB first; bitCnt+1; after the 8th bit -> PARITY.
  - PARITY: on fall, latch the parity bit -> STOP.
  - STOP: on fall, check stop=1 and odd parity (XOR of 8 data bits and parity = 1).
    - Pass -> push the byte, return to IDLE.
    - Fail -> frameErr, return to IDLE.
- Timeout:
  - Counter clears on every fall and in IDLE; increments in all other states.
  - Reaching TIMEOUT: frameErr pulse, FSM -> IDLE, partial byte discarded.
- FIFO:
  - Push occurs in the cycle after the STOP fall; rdValid is high the cycle after the push.
  - Pop when rdEn && rdValid; rdData updates the next cycle. rdEn while empty is ignored (no underflow, count stays 0).
  - Push and pop in the same cycle: both take effect, count unchanged. This also applies when full: the push is accepted.
  - Push while full without a pop: byte dropped, overflow pulse, FIFO contents unchanged.
  - Pointers wrap modulo 2**FIFO_AW; count is the pointer difference with the extra MSB.
- ps2Inhibit:
  - Registered; equals (count == 2**FIFO_AW).
  - Rises the cycle after the push that fills the FIFO; falls the cycle after the first pop.
  - The FSM keeps running while inhibited. A frame already in flight completes normally or times out.
- Simultaneous frame error and timeout: a single frameErr pulse.

Optional Feature:
- Macro PS2_RX_ERRCNT_EN.
- Defined:
  - errCount increments on each frameErr or overflow pulse and saturates at 8'hFF.
  - If both pulse in the same cycle, it increments by 1 only.
  - Cleared only by reset.
- Undefined: errCount tied to 8'h00 and no counter logic is generated.

Test Plan:
- Idle bus after reset -> rdValid=0, count=0, ps2Inhibit=0, errCount=0. rdEn pulses change nothing.
- One frame, byte 8'h1C, parity 0, stop 1, 40 us bit period -> rdValid rises the cycle after the push, rdData=8'h1C, count=1. One rdEn pulse -> rdValid=0.
- Frame 8'h1C with parity bit 1 -> frameErr pulses once, FIFO empty, errCount=1 with the macro defined.
- Eight good frames (8'h01..8'h08) with no reads -> ps2Inhibit=1 after the 8th push. A 9th frame 8'h09 -> overflow pulse. Reads return 8'h01..8'h08 in order, and ps2Inhibit falls after the first pop.
- Stop driving ps2CLK after the 4th data bit -> frameErr exactly TIMEOUT cycles after the last fall. A following good frame 8'hF0 is received correctly.
- 1-cycle glitches on ps2CLK during a good frame of 8'h5A -> byte 8'h5A stored, no frameErr. rst_in asserted mid-frame -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: read-side bundle of the PS/2 receive FIFO.
//   rdEn    - consumer pops the head entry (honoured only while rdValid=1)
//   rdData  - head entry, meaningful only while rdValid=1
//   rdValid - FIFO not empty
//   count   - entries currently held (FIFO_AW+1 bits)
// modport master: the FIFO side; modport slave: the consumer side.
interface ps2_rx_fifo_if #(
  parameter int unsigned FIFO_AW = 3
);
  logic               rdEn;
  logic [7:0]         rdData;
  logic               rdValid;
  logic [FIFO_AW:0]   count;

  modport master (input rdEn, output rdData, output rdValid, output count);
  modport slave  (output rdEn, input rdData, input rdValid, input count);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receive front end.
// Synchronises and deglitches raw ps2CLK/ps2DATA, deframes 11-bit
// device-to-host frames (start, 8 data LSB first, odd parity, stop) and
// buffers good bytes in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_in   - system clock, asynchronous active-low reset
//   ps2CLK/DATA   - raw asynchronous PS/2 lines
//   rd            - ps2_rx_fifo_if.master read port (rdEn/rdData/rdValid/count)
//   ps2Inhibit    - registered FIFO-full flag
//   frameErr      - one-cycle pulse per rejected or timed-out frame
//   overflow      - one-cycle pulse per good byte dropped while full
//   errCount      - saturating count of frameErr/overflow pulses
// Optional feature: define PS2_RX_ERRCNT_EN to build the error counter;
// otherwise errCount is tied to zero.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned TO_W       = 17
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 ps2CLK,
  input  logic                 ps2DATA,
  ps2_rx_fifo_if.master        rd,
  output logic                 ps2Inhibit,
  output logic                 frameErr,
  output logic                 overflow,
  output logic [7:0]           errCount
);

  localparam int unsigned        DEPTH    = 2**FIFO_AW;
  localparam int unsigned        FC_W     = $clog2(FILTER_LEN + 1);
  localparam logic [FC_W-1:0]    FLT_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  // Input conditioning
  logic [1:0]      clk_sync_q, clk_sync_d;
  logic [1:0]      data_sync_q, data_sync_d;
  logic            clk_filt_q, clk_filt_d;
  logic            data_filt_q, data_filt_d;
  logic [FC_W-1:0] clk_fcnt_q, clk_fcnt_d;
  logic [FC_W-1:0] data_fcnt_q, data_fcnt_d;
  logic            clk_prev_q, clk_prev_d;
  logic            fall;

  // Deframer
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            frame_err_q, frame_err_d;
  logic            push_q, push_d;
  logic [7:0]      push_byte_q, push_byte_d;

  // FIFO
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             inhibit_q, inhibit_d;
  logic             overflow_q, overflow_d;
  logic [FIFO_AW:0] cnt;
  logic             rd_valid;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign cnt      = wr_ptr_q - rd_ptr_q;
  assign rd_valid = (cnt != '0);
  assign full     = (cnt == FULL_CNT);
  assign pop      = rd.rdEn && rd_valid;
  // A push into a full FIFO is still accepted when a pop frees the slot
  // in the same cycle.
  assign wr_en    = push_q && (!full || pop);
  assign fall     = clk_prev_q && !clk_filt_q;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2CLK};
    data_sync_d = {data_sync_q[0], ps2DATA};

    clk_filt_d  = clk_filt_q;
    clk_fcnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_fcnt_q == FLT_LAST) clk_filt_d = clk_sync_q[1];
      else                        clk_fcnt_d = clk_fcnt_q + 1'b1;
    end

    data_filt_d = data_filt_q;
    data_fcnt_d = '0;
    if (data_sync_q[1] != data_filt_q) begin
      if (data_fcnt_q == FLT_LAST) data_filt_d = data_sync_q[1];
      else                         data_fcnt_d = data_fcnt_q + 1'b1;
    end

    clk_prev_d = clk_filt_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    push_byte_d = push_byte_q;
    frame_err_d = 1'b0;
    push_d      = 1'b0;

    if (state_q == IDLE || fall) to_cnt_d = '0;
    else                         to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      IDLE: if (fall) begin
        if (!data_filt_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_d   = {data_filt_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = data_filt_q;
        state_d = STOP;
      end
      STOP: if (fall) begin
        if (data_filt_q && (^{shift_q, par_q})) begin
          push_d      = 1'b1;
          push_byte_d = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timeout only fires on a no-fall cycle, so it can never coincide with
    // a fall-detected error: frameErr is at most one pulse per frame.
    if (state_q != IDLE && !fall && to_cnt_q == TO_LAST) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = push_q && full && !pop;
    if (wr_en) begin
      mem_d[wr_ptr_q[FIFO_AW-1:0]] = push_byte_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    inhibit_d = ((wr_ptr_d - rd_ptr_d) == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_fcnt_q  <= '0;
      data_fcnt_q <= '0;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inhibit_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_fcnt_q  <= clk_fcnt_d;
      data_fcnt_q <= data_fcnt_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inhibit_q   <= inhibit_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array carries no reset; rdData is masked while empty instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd.rdData   = rd_valid ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : '0;
  assign rd.rdValid  = rd_valid;
  assign rd.count    = cnt;
  assign ps2Inhibit  = inhibit_q;
  assign frameErr    = frame_err_q;
  assign overflow    = overflow_q;

`ifdef PS2_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // A coincident frameErr and overflow count as a single event.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((frame_err_q || overflow_q) && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign errCount = err_cnt_q;
`else
  assign errCount = '0;
`endif

endmodule
